fetch_stage: RTL and testbench

- Producer end of the instruction interface that the decode stage consumes.
- Holds the fetch PC and issues 16-bit reads on the instruction-memory port (read held until resp), then buffers returned words with their PCs in a small FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- Accepts branch/jump/trap redirects from later stages, flushes the buffer and drains any in-flight read.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 71 +++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory port, redirect input and decode-facing handshake of the fetch stage.
interface fetch_stage_if;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        dec_ready;
    logic        if_valid;
    logic [15:0] if_instruction;
    logic [15:0] if_pc;
    logic [15:0] if_npc;
    modport master (
        output imem_read, imem_address, if_valid, if_instruction, if_pc, if_npc,
        input  imem_rdata, imem_resp, redirect, redirect_pc, dec_ready
    );
    modport slave (
        input  imem_read, imem_address, if_valid, if_instruction, if_pc, if_npc,
        output imem_rdata, imem_resp, redirect, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: fetches 16-bit words into a small PC-tagged FIFO for decode; redirects flush it and drain any in-flight read.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic {FETCH, DRAIN} state_t;
    state_t        state, next_state;
    logic [15:0]   fetch_pc, drain_addr;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [15:0]   pc_mem  [DEPTH];
    logic [15:0]   ins_mem [DEPTH];
    logic          push, pop;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= next_state;
    end
    // A redirect with a read still waiting must drain it; a same-cycle response simply completes it.
    always_comb begin
        next_state = state;
        if (bus.redirect)                          next_state = (bus.imem_read && !bus.imem_resp) ? DRAIN : FETCH;
        else if (state == DRAIN && bus.imem_resp)  next_state = FETCH;
    end
    always_comb begin
        bus.imem_read      = reset_n && (state == DRAIN || count < FULL);
        bus.imem_address   = (state == DRAIN) ? drain_addr : fetch_pc;
        bus.if_valid       = (count != '0);
        bus.if_instruction = ins_mem[rd_ptr];
        bus.if_pc          = pc_mem[rd_ptr];
        bus.if_npc         = pc_mem[rd_ptr] + 16'd2;
    end
    assign push = (state == FETCH) && bus.imem_read && bus.imem_resp && !bus.redirect;
    assign pop  = bus.if_valid && bus.dec_ready && !bus.redirect;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else begin
            // Tracks the outstanding address so a later redirect knows what to drain.
            if (state == FETCH) drain_addr <= fetch_pc;
            if (bus.redirect) begin
                fetch_pc <= {bus.redirect_pc[15:1], 1'b0};
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (push) begin
                    pc_mem[wr_ptr]  <= fetch_pc;
                    ins_mem[wr_ptr] <= bus.imem_rdata;
                    wr_ptr          <= wr_ptr + 1'b1;
                    fetch_pc        <= fetch_pc + 16'd2;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch/redirect traffic; a scoreboard of the expected program-order stream is checked on every decode accept.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    fetch_stage_if bus();
    fetch_stage #(.RESET_PC(16'h0000), .DEPTH(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct packed {logic [15:0] pc; logic [15:0] ins; logic [15:0] npc;} exp_t;
    exp_t        exp_q[$];
    logic [15:0] exp_next;
    logic [15:0] rd_log[$];
    int          n_checks = 0, n_fail = 0, n_accepted = 0;
    int          lat = 1;
    int          wait_cnt = 0;
    logic        prev_pend = 1'b0;
    logic [15:0] prev_addr = '0;
    function automatic logic [15:0] mem(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction
    function automatic int pick();
        return (lat < 0) ? int'($urandom_range(0, 3)) : lat;
    endfunction
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask
    task automatic top_up();
        while (exp_q.size() < 32) begin
            exp_q.push_back({exp_next, mem(exp_next), exp_next + 16'd2});
            exp_next += 16'd2;
        end
    endtask
    // The expected stream restarts at the (even) target; anything older is never to be seen again.
    task automatic seed(input logic [15:0] pc);
        exp_q.delete();
        exp_next = {pc[15:1], 1'b0};
        top_up();
    endtask
    task automatic step();
        @(negedge clk);
        #1;
        top_up();
    endtask
    task automatic do_redirect(input logic [15:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        seed(pc);
        step();
        bus.redirect = 1'b0;
    endtask
    task automatic apply_reset();
        reset_n    = 1'b0;
        bus.redirect = 1'b0;
        seed(16'h0000);
        step();
        step();
        reset_n = 1'b1;
    endtask
    // Memory model: answers after a chosen number of wait cycles, 0 meaning same cycle as the request.
    always @(negedge clk) begin
        if (!reset_n || bus.imem_read !== 1'b1) begin
            bus.imem_resp = 1'b0;
            wait_cnt      = pick();
        end else if (wait_cnt == 0) begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = mem(bus.imem_address);
            wait_cnt       = pick();
        end else begin
            bus.imem_resp = 1'b0;
            wait_cnt--;
        end
    end
    always @(negedge clk) begin
        #2;
        if (!reset_n) prev_pend = 1'b0;
        else begin
            if (prev_pend) begin
                check("read_held", 16'(bus.imem_read), 16'd1);
                check("addr_stable", bus.imem_address, prev_addr);
            end
            prev_pend = bus.imem_read && !bus.imem_resp;
            prev_addr = bus.imem_address;
            if (bus.imem_read && bus.imem_resp) rd_log.push_back(bus.imem_address);
            if (bus.if_valid && bus.dec_ready && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got pc %h, expected nothing queued", bus.if_pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("if_pc", bus.if_pc, e.pc);
                    check("if_instruction", bus.if_instruction, e.ins);
                    check("if_npc", bus.if_npc, e.npc);
                    n_accepted++;
                end
            end
        end
    end
    initial begin
        int k, snap;
        logic [15:0] a;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready   = 1'b0;
        seed(16'h0000);
        #1;
        check("rst_if_valid", 16'(bus.if_valid), 16'd0);
        check("rst_if_instruction", bus.if_instruction, 16'h0000);
        check("rst_if_pc", bus.if_pc, 16'h0000);
        check("rst_if_npc", bus.if_npc, 16'h0002);
        check("rst_imem_address", bus.imem_address, 16'h0000);
        check("rst_imem_read", 16'(bus.imem_read), 16'd0);
        step();
        step();
        reset_n = 1'b1;
        lat = 1;
        bus.dec_ready = 1'b1;
        rd_log.delete();
        repeat (20) step();
        check("t1_rd_count_ok", 16'(rd_log.size() >= 3), 16'd1);
        if (rd_log.size() >= 3) begin
            check("t1_rd0", rd_log[0], 16'h0000);
            check("t1_rd1", rd_log[1], 16'h0002);
            check("t1_rd2", rd_log[2], 16'h0004);
        end
        check("t1_progress", 16'(n_accepted >= 5), 16'd1);
        apply_reset();
        lat = 1;
        bus.dec_ready = 1'b0;
        rd_log.delete();
        repeat (10) step();
        check("t2_reads", 16'(rd_log.size()), 16'd2);
        if (rd_log.size() == 2) begin
            check("t2_rd0", rd_log[0], 16'h0000);
            check("t2_rd1", rd_log[1], 16'h0002);
        end
        check("t2_read_idle", 16'(bus.imem_read), 16'd0);
        check("t2_head_pc", bus.if_pc, 16'h0000);
        check("t2_valid", 16'(bus.if_valid), 16'd1);
        bus.dec_ready = 1'b1;
        step();
        check("t2_read_resume", 16'(bus.imem_read), 16'd1);
        check("t2_addr_resume", bus.imem_address, 16'h0004);
        apply_reset();
        lat = 3;
        bus.dec_ready = 1'b1;
        rd_log.delete();
        k = 0;
        while (!(bus.imem_read && bus.imem_address == 16'h0004 && !bus.imem_resp) && k < 50) begin
            step();
            k++;
        end
        check("t3_wait_read4", 16'(k < 50), 16'd1);
        snap = n_accepted;
        do_redirect(16'h3001);
        check("t3_drain_addr", bus.imem_address, 16'h0004);
        check("t3_drain_read", 16'(bus.imem_read), 16'd1);
        check("t3_flushed", 16'(bus.if_valid), 16'd0);
        lat = 1;
        repeat (15) step();
        check("t3_rd_count_ok", 16'(rd_log.size() >= 4), 16'd1);
        if (rd_log.size() >= 4) begin
            check("t3_drained", rd_log[2], 16'h0004);
            check("t3_target", rd_log[3], 16'h3000);
        end
        check("t3_progress", 16'(n_accepted > snap), 16'd1);
        lat = 0;
        k = 0;
        while (!(bus.imem_resp && bus.if_valid) && k < 50) begin
            step();
            k++;
        end
        check("t4_wait_resp", 16'(k < 50), 16'd1);
        do_redirect(16'h8000);
        check("t4_valid", 16'(bus.if_valid), 16'd0);
        check("t4_read", 16'(bus.imem_read), 16'd1);
        check("t4_addr", bus.imem_address, 16'h8000);
        lat = -1;
        snap = n_accepted;
        do_redirect(16'hFFFA);
        repeat (30) step();
        check("t5_wrap_progress", 16'(n_accepted - snap >= 5), 16'd1);
        snap = n_accepted;
        repeat (600) begin
            bus.dec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) do_redirect(16'($urandom));
            else step();
        end
        check("t6_progress", 16'(n_accepted - snap >= 50), 16'd1);
        lat = 3;
        bus.dec_ready = 1'b0;
        k = 0;
        while (!(bus.imem_read && !bus.imem_resp && wait_cnt >= 1) && k < 50) begin
            step();
            k++;
        end
        check("t7_wait_read", 16'(k < 50), 16'd1);
        a = bus.imem_address;
        do_redirect(16'h1234);
        check("t7_drain_addr", bus.imem_address, a);
        reset_n = 1'b0;
        #1;
        check("t7_rst_valid", 16'(bus.if_valid), 16'd0);
        check("t7_rst_read", 16'(bus.imem_read), 16'd0);
        seed(16'h0000);
        step();
        step();
        rd_log.delete();
        lat = 1;
        bus.dec_ready = 1'b1;
        reset_n = 1'b1;
        repeat (10) step();
        check("t7_rd_count_ok", 16'(rd_log.size() >= 1), 16'd1);
        if (rd_log.size() >= 1) check("t7_first_read", rd_log[0], 16'h0000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
